muldiv_seq: RTL and testbench

Sequencer for the execute stage's shared multiplier and divider units. It accepts one HI/LO-class instruction at a time and performs operand sign pre-processing. It issues the operation to the `mult` or `div` unit over their valid/done handshake, applies sign correction and accumulation to the result, and holds the pipeline with `stall` until a registered result is ready. It sits between instruction decode of the execute stage and the two arithmetic units, replacing ad-hoc per-instruction sequencing.

---
 rtl/muldiv_seq.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences HI/LO-class instructions onto the shared unsigned
// multiplier and divider. Signed operands are issued to the units as
// magnitudes, and sign correction and HI/LO accumulation are applied to the
// result on the way back. `stall` holds F/D/E until the result is registered.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   flush                    kill the instruction in flight
//   in_valid, op, a, b       instruction in E (op 0..8 legal), rs/rt values
//   hi_in, lo_in             current HI/LO (accumulate ops)
//   advance                  E hands its instruction to M this cycle
//   stall                    hold F/D/E (combinational)
//   res_valid, res_hi/lo     registered result, hi_we/lo_we write enables
//   mul_* / div_*            valid/done handshake to the unsigned units;
//                            div_c = {remainder, quotient}
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        advance,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        hi_we,
  output logic        lo_we,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c,
  output logic        div_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [63:0] div_c
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [3:0] OP_MULTU = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  logic [1:0]  state;
  logic [3:0]  op_r;
  logic        sa_r, sb_r;   // operand signs, only ever set for signed ops
  logic        div_r;
  logic [31:0] hi_r, lo_r;

  logic        legal, signed_in, div_in, accept, unit_done;
  logic [31:0] a_opnd, b_opnd;
  logic [63:0] prod, acc, mul_res;
  logic [31:0] quo, rem;

  // NOTE: every signal assigned in always_comb gets a default at the top, so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    legal     = (op <= OP_MSUBU);
    signed_in = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL) ||
                (op == OP_MADD) || (op == OP_MSUB);
    div_in    = (op == OP_DIVU) || (op == OP_DIV);
    accept    = (state == S_IDLE) && in_valid && legal && !flush;
    a_opnd    = (signed_in && a[31]) ? 32'd0 - a : a;
    b_opnd    = (signed_in && b[31]) ? 32'd0 - b : b;
    unit_done = (mul_valid && mul_done) || (div_valid && div_done);

    // Product of magnitudes gets the sign back, then optional accumulation.
    prod = (sa_r ^ sb_r) ? 64'd0 - mul_c : mul_c;
    acc  = {hi_r, lo_r};
    case (op_r)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase

    // Truncating signed division: quotient sign from both operands,
    // remainder sign follows the dividend.
    quo = div_c[31:0];
    rem = div_c[63:32];
    if (sa_r ^ sb_r) quo = 32'd0 - quo;
    if (sa_r)        rem = 32'd0 - rem;

    stall = accept || (state == S_BUSY) || ((state == S_DRAIN) && in_valid);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_r      <= 4'd0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      div_r     <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      res_valid <= 1'b0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      hi_we     <= 1'b0;
      lo_we     <= 1'b0;
      mul_valid <= 1'b0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      div_valid <= 1'b0;
      div_a     <= 32'd0;
      div_b     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r  <= op;
            sa_r  <= signed_in && a[31];
            sb_r  <= signed_in && b[31];
            div_r <= div_in;
            hi_r  <= hi_in;
            lo_r  <= lo_in;
            if (div_in && (b == 32'd0)) begin
              // Divide by zero never reaches the divider.
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_hi    <= a;
              res_lo    <= 32'hFFFF_FFFF;
              hi_we     <= 1'b1;
              lo_we     <= 1'b1;
            end else if (div_in) begin
              state     <= S_BUSY;
              div_valid <= 1'b1;
              div_a     <= a_opnd;
              div_b     <= b_opnd;
            end else begin
              state     <= S_BUSY;
              mul_valid <= 1'b1;
              mul_a     <= a_opnd;
              mul_b     <= b_opnd;
            end
          end
        end
        S_BUSY: begin
          if (unit_done) begin
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_hi    <= div_r ? rem : mul_res[63:32];
              res_lo    <= div_r ? quo : mul_res[31:0];
              hi_we     <= (op_r != OP_MUL);
              lo_we     <= (op_r != OP_MUL);
            end
          end else if (flush) begin
            // The unit cannot be aborted; let it finish and discard the result.
            state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (flush || advance) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            hi_we     <= 1'b0;
            lo_we     <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (unit_done) begin
            state     <= S_IDLE;
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, multi-cycle
// corner sequences (flush, reset, illegal op) and random ops compared with a
// plain-arithmetic reference model. Unit models have settable latency.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, advance;
  logic [3:0]  op;
  logic [31:0] a, b, hi_in, lo_in;
  logic        stall, res_valid, hi_we, lo_we;
  logic [31:0] res_hi, res_lo;
  logic        mul_valid, mul_done, div_valid, div_done;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_c, div_c;

  int n_cmp  = 0;
  int n_fail = 0;
  int mul_lat = 3;
  int div_lat = 4;
  int mul_cnt = 0;
  int div_cnt = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .op(op),
    .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .advance(advance),
    .stall(stall), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .hi_we(hi_we), .lo_we(lo_we),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c),
    .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_c(div_c)
  );

  // Unit models: done after `lat` cycles of valid.
  always @(posedge clk) begin
    mul_cnt <= (!mul_valid || mul_done) ? 0 : mul_cnt + 1;
    div_cnt <= (!div_valid || div_done) ? 0 : div_cnt + 1;
  end
  assign mul_done = mul_valid && (mul_cnt == mul_lat);
  assign div_done = div_valid && (div_cnt == div_lat);
  assign mul_c    = {32'd0, mul_a} * {32'd0, mul_b};
  assign div_c    = (div_b == 32'd0) ? 64'd0 : {div_a % div_b, div_a / div_b};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model straight from the instruction definitions.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] x, y, h, l,
                                 output logic [31:0] eh, el, output logic ewe);
    logic [63:0] ps, pu, accv, r;
    longint nx, ny;
    ps   = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    pu   = {32'd0, x} * {32'd0, y};
    accv = {h, l};
    ewe  = 1'b1;
    case (o)
      4'd0: r = pu;
      4'd1: r = ps;
      4'd2, 4'd3: begin
        if (y == 32'd0)  r = {x, 32'hFFFF_FFFF};
        else if (o == 4'd2) r = {x % y, x / y};
        else begin
          nx = longint'(int'(x));
          ny = longint'(int'(y));
          r  = {32'(nx % ny), 32'(nx / ny)};
        end
      end
      4'd4: begin r = ps; ewe = 1'b0; end
      4'd5: r = accv + ps;
      4'd6: r = accv + pu;
      4'd7: r = accv - ps;
      default: r = accv - pu;
    endcase
    eh = r[63:32];
    el = r[31:0];
  endfunction

  // Issue one op, wait for the result, check it, hold one cycle, advance.
  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] x, y, h, l,
                       input logic [31:0] eh, el, input logic ewe, input bit chk_hi,
                       input int exp_lat);
    int lat, stl;
    bit ok;
    @(negedge clk);
    op = o; a = x; b = y; hi_in = h; lo_in = l; in_valid = 1'b1;
    #1;
    stl = int'(stall);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      stl += int'(stall);
      lat++;
      @(negedge clk);
      #1;
    end
    check({name, " done_in_time"}, 64'(ok), 64'd1);
    if (!ok) return;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " stall_cycles"}, 64'(stl), 64'(exp_lat));
    check({name, " stall_in_done"}, 64'(stall), 64'd0);
    if (chk_hi) check({name, " res_hi"}, 64'(res_hi), 64'(eh));
    check({name, " res_lo"}, 64'(res_lo), 64'(el));
    check({name, " we"}, {62'd0, hi_we, lo_we}, {62'd0, ewe, ewe});
    @(negedge clk);
    #1;
    check({name, " held"}, {31'd0, res_valid, res_lo}, {31'd0, 1'b1, el});
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    #1;
    check({name, " cleared"}, {res_valid, hi_we, lo_we, res_hi, res_lo}, 67'd0);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_we;
    bit          chk_hi;
    int          unit_lat;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] eh, el;
    logic        ewe;
    logic [3:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          el_lat;
    bit          done_seen, rv_seen, dv_seen;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; advance = 1'b0;
    op = 4'd0; a = 32'd0; b = 32'd0; hi_in = 32'd0; lo_in = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {stall, res_valid, hi_we, lo_we, mul_valid, div_valid, res_hi, res_lo},
          {6'd0, 64'd0});
    reset = 1'b0;

    // name, op, a, b, hi, lo, exp_hi, exp_lo, we, chk_hi, unit_lat, exp_lat
    vecs.push_back('{"mult_neg3x5", 4'd1, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b1, 3, 5});
    vecs.push_back('{"div_neg7by2", 4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1, 4, 6});
    vecs.push_back('{"divu_7by2",   4'd2, 32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 1'b1, 1'b1, 2, 4});
    vecs.push_back('{"divu_by0",    4'd2, 32'h1234, 32'd0, 32'd0, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b1, 4, 1});
    vecs.push_back('{"div_by0_neg", 4'd3, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 4, 1});
    vecs.push_back('{"madd",        4'd5, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, 32'd0, 32'd4, 1'b1, 1'b1, 1, 3});
    vecs.push_back('{"msubu",       4'd8, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 2});
    vecs.push_back('{"msub",        4'd7, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5, 32'd0, 32'd11, 1'b1, 1'b1, 2, 4});
    vecs.push_back('{"maddu_carry", 4'd6, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1, 3});
    vecs.push_back('{"mul_gpr",     4'd4, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF1, 1'b0, 1'b0, 2, 4});
    vecs.push_back('{"div_neg_neg", 4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd3, 1'b1, 1'b1, 1, 3});

    for (int i = 0; i < vecs.size(); i++) begin
      mul_lat = vecs[i].unit_lat;
      div_lat = vecs[i].unit_lat;
      dv_seen = 1'b0;
      fork
        begin
          do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_we, vecs[i].chk_hi, vecs[i].exp_lat);
        end
        begin
          for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            if (div_valid) dv_seen = 1'b1;
          end
        end
      join_any
      disable fork;
      if (vecs[i].exp_lat == 1) check({vecs[i].name, " div_valid_never"}, 64'(dv_seen), 64'd0);
    end

    // Illegal op and flush in IDLE: nothing is issued.
    @(negedge clk);
    op = 4'd9; in_valid = 1'b1;
    #1;
    check("illegal_stall", 64'(stall), 64'd0);
    @(negedge clk);
    op = 4'd0; flush = 1'b1;
    #1;
    check("idle_flush_stall", 64'(stall), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_no_issue", {res_valid, mul_valid, div_valid}, 64'd0);

    // Flush in the 2nd BUSY cycle of a DIV: divider drains, no result.
    div_lat = 4;
    @(negedge clk);
    op = 4'd3; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("drain_stall_idle", 64'(stall), 64'd0);
    check("drain_div_valid", 64'(div_valid), 64'd1);
    in_valid = 1'b1; op = 4'd0;
    #1;
    check("drain_stall_in_valid", 64'(stall), 64'd1);
    in_valid = 1'b0;
    done_seen = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid) rv_seen = 1'b1;
      if (!div_valid) break;
      if (div_done) done_seen = 1'b1;
      @(negedge clk);
      #1;
    end
    check("drain_waited_done", {done_seen, div_valid}, {1'b1, 1'b0});
    check("drain_no_result", 64'(rv_seen | res_valid), 64'd0);
    check("drain_idle_stall", 64'(stall), 64'd0);
    do_op("after_drain", 4'd2, 32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 1'b1, 1'b1, 6);

    // Flush together with advance in DONE drops the result.
    mul_lat = 0;
    @(negedge clk);
    op = 4'd0; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("flushdone_valid", {res_valid, res_lo}, {1'b1, 32'd42});
    flush = 1'b1; advance = 1'b1;
    @(negedge clk);
    flush = 1'b0; advance = 1'b0;
    #1;
    check("flushdone_dropped", {res_valid, res_hi, res_lo}, 65'd0);

    // Reset in the middle of BUSY.
    mul_lat = 3;
    @(negedge clk);
    op = 4'd1; a = 32'hFFFFFFFD; b = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("busy_reset_outputs",
          {stall, res_valid, hi_we, lo_we, mul_valid, div_valid, res_hi, res_lo, mul_a, mul_b},
          {6'd0, 128'd0});
    reset = 1'b0;
    do_op("multu_after_reset", 4'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFE, 1'b1, 1'b1, 5);

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      rh = $urandom;
      rl = $urandom;
      mul_lat = $urandom_range(0, 4);
      div_lat = $urandom_range(0, 4);
      ref_op(ro, ra, rb, rh, rl, eh, el, ewe);
      if (ro == 4'd2 || ro == 4'd3) el_lat = (rb == 32'd0) ? 1 : div_lat + 2;
      else el_lat = mul_lat + 2;
      do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rh, rl, eh, el, ewe, ro != 4'd4, el_lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
